// File: rtl/tff_ctrl_pkg.sv
// Shared state encoding and default width for the toggle-bank sequencer.
package tff_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tff_rst.sv
// Single T flip-flop with asynchronous active-low reset to 0.
module tff_rst (
  input  logic T,
  input  logic clk,
  input  logic rst_n,
  output logic Q,
  output logic notQ
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

  assign notQ = ~Q;

endmodule

// File: rtl/tff_seq_ctrl.sv
// Up/down counter sequencer built from a bank of T flip-flops.
module tff_seq_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] tog,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nx;
  logic             up_q;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] sv;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             load_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_rst u_ff (
      .T     (tog[i]),
      .clk   (clk),
      .rst_n (rst_n),
      .Q     (count[i]),
      .notQ  (nq[i])
    );
  end

  assign load_en = (state == S_IDLE) && start && !stop;
  assign sv      = up_q ? '0 : lim_q;
  assign ev      = up_q ? lim_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      up_q  <= 1'b0;
      lim_q <= '0;
    end else begin
      state <= state_nx;
      if (load_en) begin
        up_q  <= up;
        lim_q <= limit;
      end
    end
  end

  // Ripple-carry style toggle terms: bit i flips when all lower bits
  // are 1 (counting up) or all lower bits are 0 (counting down).
  always_comb begin
    logic cu;
    logic cd;
    up_t = '0;
    dn_t = '0;
    cu   = 1'b1;
    cd   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = cu;
      dn_t[i] = cd;
      cu      = cu & count[i];
      cd      = cd & nq[i];
    end
  end

  always_comb begin
    state_nx = state;
    tog      = '0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else begin
          tog      = count ^ sv;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (count == ev) begin
          state_nx = S_DONE;
        end else begin
          tog = up_q ? up_t : dn_t;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        done     = !stop;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed checks of the toggle-bank sequencer.
module tb_tff_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       up;
  logic [3:0] limit;
  logic [3:0] count;
  logic [3:0] tog;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  tff_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .up    (up),
    .limit (limit),
    .count (count),
    .tog   (tog),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input int c,
                        input bit b, input bit d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    up    = 1'b0;
    limit = 4'd0;

    // 1: async reset, checked before any edge
    #3 rst_n = 1'b0;
    #1;
    chk_st("rst", 0, 1'b0, 1'b0);
    chk("rst.tog", 32'(tog), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_st("rst_idle", 0, 1'b0, 1'b0);

    // 2: up to 3, with a start re-pulse while busy
    up = 1'b1; limit = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2.load_busy", 32'(busy), 1);
    chk("t2.load_tog", 32'(tog), 0);
    tick(); chk_st("t2.e1", 0, 1'b1, 1'b0);
    tick(); chk_st("t2.e2", 1, 1'b1, 1'b0);
    start = 1'b1; up = 1'b0; limit = 4'd9;
    tick(); chk_st("t2.e3", 2, 1'b1, 1'b0);
    start = 1'b0; up = 1'b1; limit = 4'd3;
    tick(); chk_st("t2.e4", 3, 1'b1, 1'b0);
    tick(); chk_st("t2.e5", 3, 1'b1, 1'b1);
    chk("t2.done_tog", 32'(tog), 0);
    tick(); chk_st("t2.e6", 3, 1'b0, 1'b0);

    // 3: down from 5 starting at count=3
    up = 1'b0; limit = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3.load_tog", 32'(tog), 6);
    for (int k = 0; k <= 5; k++) begin
      tick();
      chk_st($sformatf("t3.e%0d", k + 1), 5 - k, 1'b1, 1'b0);
    end
    tick(); chk_st("t3.e7", 0, 1'b1, 1'b1);
    tick(); chk_st("t3.e8", 0, 1'b0, 1'b0);

    // 4: full range up, no wrap
    up = 1'b1; limit = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      tick();
      chk_st($sformatf("t4.e%0d", k + 1), k, 1'b1, 1'b0);
    end
    tick(); chk_st("t4.e17", 15, 1'b1, 1'b1);
    chk("t4.done_tog", 32'(tog), 0);
    tick(); chk_st("t4.e18", 15, 1'b0, 1'b0);

    // 5: stop mid-run, then start+stop together in IDLE
    up = 1'b1; limit = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5.load_tog", 32'(tog), 15);
    tick(); chk_st("t5.e1", 0, 1'b1, 1'b0);
    tick(); chk_st("t5.e2", 1, 1'b1, 1'b0);
    tick(); chk_st("t5.e3", 2, 1'b1, 1'b0);
    stop = 1'b1;
    #1 chk("t5.stop_tog", 32'(tog), 0);
    tick(); chk_st("t5.e4", 2, 1'b0, 1'b0);
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk_st("t5.after", 2, 1'b0, 1'b0);
    end
    start = 1'b1; stop = 1'b1;
    tick(); chk_st("t5.ss", 2, 1'b0, 1'b0);
    tick(); chk_st("t5.ss2", 2, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;

    // 6a: limit=0 upward
    up = 1'b1; limit = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6u.load_tog", 32'(tog), 2);
    tick(); chk_st("t6u.e1", 0, 1'b1, 1'b0);
    tick(); chk_st("t6u.e2", 0, 1'b1, 1'b1);
    tick(); chk_st("t6u.e3", 0, 1'b0, 1'b0);

    // 6b: limit=0 downward
    up = 1'b0; limit = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); chk_st("t6d.e1", 0, 1'b1, 1'b0);
    tick(); chk_st("t6d.e2", 0, 1'b1, 1'b1);
    tick(); chk_st("t6d.e3", 0, 1'b0, 1'b0);

    // 6c: reset mid-run
    up = 1'b0; limit = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); chk_st("t6r.e1", 5, 1'b1, 1'b0);
    tick(); chk_st("t6r.e2", 4, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_st("t6r.rst", 0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); chk_st("t6r.post", 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
